dm_responder: RTL and testbench
===============================

# dm_responder

Shared data-memory responder and run sequencer for the multicore matrix-multiplication array. It is the memory-side end of each processor core's data interface: it serves core data addresses with registered read data and accepts core write requests through a round-robin single write port. It drives each core's 2-bit `status`, stalling a core while its write is pending. It also gathers `end_process` from all cores into one `done`, and gives a host port for loading operands and reading results while the array is idle.

## Interface
Parameters:
- `NCORES`, 4, number of processor cores served (≥2)
- `AW`, 8, data-memory address width; depth 2^AW words of 16 bits

Ports:
- `clock` in 1: single clock, all state on posedge
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: pulse; begins a run from IDLE or DONE
- `core_addr` in NCORES*16: core i data address in bits [16i+15:16i]; only [AW-1:0] are used
- `core_wdata` in NCORES*16: core i write data
- `core_we` in NCORES: core i write request (core's `dm_en`)
- `core_end` in NCORES: core i `end_process`
- `core_status` out NCORES*2: per core: 00 idle, 01 run, 10 stall, 11 finished
- `core_rdata` out NCORES*16: registered read data to core i (`dm_out`)
- `host_addr` in AW: host address
- `host_wdata` in 16: host write data
- `host_we` in 1: host write
- `host_rdata` out 16: registered host read data
- `busy` out 1: high in RUN
- `done` out 1: high in DONE

## Operation
- Top FSM: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when every core is finished and every write slot is empty.
  - DONE→RUN on `start`, which clears the finished flags.
  - `start` is ignored in RUN.
- Status in IDLE: all cores 00.
- Status in RUN, per core:
  - 11 if the finished flag is set and the slot is empty.
  - Else 10 if the slot is full.
  - Else 01.
- Status in DONE: all cores 11.
- Reads:
  - Every cycle, in every state, `core_rdata[i] <= mem[core_addr[i][AW-1:0]]`.
  - Every cycle, `host_rdata <= mem[host_addr]`.
  - Read-before-write: a read at the same edge as a commit returns the old word. There is no bypass.
- Write capture: in RUN, if core i's status is 01 and `core_we[i]` is high, {addr, wdata} is latched into slot i and the slot is marked full.
- Write commit:
  - At most one slot commits per edge.
  - The arbiter picks the full slot with the lowest cyclic index ≥ `rr_ptr`, writes mem, and empties that slot.
  - After a commit, `rr_ptr <=` granted index + 1 mod NCORES.
  - `rr_ptr` is unchanged if no slot is full.
  - A slot captured at edge N is eligible for commit from edge N+1.
- Finish:
  - `core_end[i]` sampled high in RUN sets finished flag i (sticky).
  - A write captured in the same cycle is still committed; status becomes 11 only after that slot empties.
- Host: `host_we` writes mem only in IDLE or DONE. It is ignored in RUN.
- Memory contents are not reset.

## Timing
- Reset values: `core_status` all 00, `core_rdata` 0, `host_rdata` 0, `busy` 0, `done` 0. Also: state IDLE, slots empty, finished flags clear, `rr_ptr` 0.
- Reset mid-RUN drops pending slots without writing them.
- Read latency is 1 cycle: an address applied before edge N gives data valid after edge N.
- Uncontended write:
  - Capture at edge N, status 10 after N.
  - Commit at N+1, status 01 after N+1.
  - The core is stalled exactly 1 cycle.
- With k slots contending, the worst-case stall is k cycles.
- `busy`/`done` change on the edge the state changes.
- `done` goes high one edge after the last slot commits, given all flags are set.
- `start` in IDLE: status becomes 01 after the same edge.

## Test plan
- Host load then readback: in IDLE, write mem[5]=0x1234; set `host_addr`=5 → `host_rdata`=0x1234 one cycle later. Reset → all outputs 0, status 00.
- Single write: `start`; core0 writes 0xBEEF at addr 3 → core0 status 10 for exactly 1 cycle. Core1 reading addr 3 gets the old value at the commit edge and 0xBEEF the cycle after.
- Contention: all 4 cores write at the same edge with `rr_ptr`=0 → commits in order 0,1,2,3 on consecutive edges, stalls of 1,2,3,4 cycles. A second burst starts at core 0 (`rr_ptr` wrapped to 0).
- Round-robin fairness: cores 1 and 3 write continuously → grants alternate 1,3,1,3; neither waits more than 2 cycles.
- Finish: `core_end` on cores 0–3 at staggered cycles, core 2 with a simultaneous write → core 2 reports 10 then 11. `done`=1 only after the last commit; `busy` falls on the same edge. A host write during RUN leaves memory unchanged.
- Reset mid-RUN with core 1 slot full → slot dropped, memory unchanged, status 00, state IDLE.

Source files
------------

// File: rtl/dm_responder.sv
// Shared data-memory responder: registered core/host reads, round-robin single
// write port fed by per-core write slots, and an IDLE/RUN/DONE run sequencer.
module dm_responder #(
  parameter int NCORES = 4,
  parameter int AW     = 8
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NCORES*16-1:0] core_addr,
  input  logic [NCORES*16-1:0] core_wdata,
  input  logic [NCORES-1:0]    core_we,
  input  logic [NCORES-1:0]    core_end,
  output logic [NCORES*2-1:0]  core_status,
  output logic [NCORES*16-1:0] core_rdata,
  input  logic [AW-1:0]        host_addr,
  input  logic [15:0]          host_wdata,
  input  logic                 host_we,
  output logic [15:0]          host_rdata,
  output logic                 busy,
  output logic                 done
);
  localparam int PW = $clog2(NCORES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;
  localparam logic [1:0] ST_FIN   = 2'b11;

  logic [1:0]        state;
  logic [NCORES-1:0] slot_full;
  logic [NCORES-1:0] fin;
  logic [AW-1:0]     slot_addr [NCORES];
  logic [15:0]       slot_data [NCORES];
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     rr_next;
  logic [15:0]       mem [2**AW];
  logic              grant_valid;
  logic [PW-1:0]     grant_idx;
  logic              all_clear;
  logic              unused_addr_bits;

  // Only the low AW bits of each core address reach the memory.
  assign unused_addr_bits = ^core_addr;

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign all_clear = (&fin) && !(|slot_full);

  // Write handshake: a core's request is taken only while its status reads 01;
  // status 10 tells it to hold until its slot has been committed.
  always_comb begin
    core_status = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (state == S_DONE) begin
        core_status[2*i +: 2] = ST_FIN;
      end else if (state == S_RUN) begin
        if (fin[i] && !slot_full[i])  core_status[2*i +: 2] = ST_FIN;
        else if (slot_full[i])        core_status[2*i +: 2] = ST_STALL;
        else                          core_status[2*i +: 2] = ST_RUN;
      end else begin
        core_status[2*i +: 2] = ST_IDLE;
      end
    end
  end

  // Scan from the far end so the candidate closest to rr_ptr wins.
  always_comb begin
    int            cand;
    logic [PW-1:0] cand_idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      cand     = (int'(rr_ptr) + k) % NCORES;
      cand_idx = PW'(cand);
      if (slot_full[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign rr_next = (grant_idx == PW'(NCORES - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      slot_full <= '0;
      fin       <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          fin   <= '0;
        end
        S_RUN: begin
          if (all_clear) state <= S_DONE;
          for (int i = 0; i < NCORES; i++)
            if (core_end[i]) fin[i] <= 1'b1;
        end
        S_DONE: if (start) begin
          state <= S_RUN;
          fin   <= '0;
        end
        default: state <= S_IDLE;
      endcase
      if (grant_valid) begin
        slot_full[grant_idx] <= 1'b0;
        rr_ptr               <= rr_next;
      end
      for (int i = 0; i < NCORES; i++) begin
        if (core_status[2*i +: 2] == ST_RUN && core_we[i]) begin
          slot_full[i] <= 1'b1;
          slot_addr[i] <= core_addr[16*i +: AW];
          slot_data[i] <= core_wdata[16*i +: 16];
        end
      end
    end
  end

  // Reset blocks the write port so a pending slot is dropped, never committed.
  always_ff @(posedge clock) begin
    if (rst_n) begin
      if (grant_valid)
        mem[slot_addr[grant_idx]] <= slot_data[grant_idx];
      else if (host_we && state != S_RUN)
        mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      core_rdata <= '0;
      host_rdata <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++)
        core_rdata[16*i +: 16] <= mem[core_addr[16*i +: AW]];
      host_rdata <= mem[host_addr];
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed scenarios plus randomized runs, every cycle
// compared against a behavioural model of memory, write slots and run phase.
module tb_dm_responder;
  localparam int NC = 4;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NC*16-1:0] core_addr;
  logic [NC*16-1:0] core_wdata;
  logic [NC-1:0] core_we;
  logic [NC-1:0] core_end;
  logic [NC*2-1:0] core_status;
  logic [NC*16-1:0] core_rdata;
  logic [AW-1:0] host_addr;
  logic [15:0]   host_wdata;
  logic          host_we;
  logic [15:0]   host_rdata;
  logic          busy;
  logic          done;

  dm_responder #(.NCORES(NC), .AW(AW)) dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_end(core_end), .core_status(core_status), .core_rdata(core_rdata),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
    .host_rdata(host_rdata), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  logic [15:0] pre [256];

  // Reference model
  typedef enum {M_IDLE, M_RUN, M_DONE} phase_t;
  phase_t      m_state;
  logic [15:0] m_mem [256];
  bit          m_known [256];
  bit          m_pend [NC];
  logic [7:0]  m_paddr [NC];
  logic [15:0] m_pdata [NC];
  bit          m_fin [NC];
  int          m_ptr;
  logic [15:0] m_crd [NC];
  bit          m_crd_ok [NC];
  logic [15:0] m_hrd;
  bit          m_hrd_ok;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  function automatic int m_status(input int i);
    if (m_state == M_IDLE) return 0;
    if (m_state == M_DONE) return 3;
    if (m_fin[i] && !m_pend[i]) return 3;
    if (m_pend[i]) return 2;
    return 1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int st_old [NC];
    bit clear;
    int a;
    int j;
    if (!rst_n) begin
      m_state = M_IDLE;
      m_ptr   = 0;
      for (int i = 0; i < NC; i++) begin
        m_pend[i] = 0; m_fin[i] = 0; m_crd[i] = '0; m_crd_ok[i] = 1;
      end
      m_hrd = '0; m_hrd_ok = 1;
      return;
    end
    clear = 1;
    for (int i = 0; i < NC; i++) begin
      st_old[i] = m_status(i);
      if (!m_fin[i] || m_pend[i]) clear = 0;
    end
    for (int i = 0; i < NC; i++) begin
      a = int'(core_addr[16*i +: 8]);
      m_crd[i] = m_mem[a];
      m_crd_ok[i] = m_known[a];
    end
    m_hrd    = m_mem[host_addr];
    m_hrd_ok = m_known[host_addr];
    for (int k = 0; k < NC; k++) begin
      j = (m_ptr + k) % NC;
      if (m_pend[j]) begin
        m_mem[m_paddr[j]] = m_pdata[j];
        m_known[m_paddr[j]] = 1;
        m_pend[j] = 0;
        m_ptr = (j + 1) % NC;
        break;
      end
    end
    if (m_state == M_RUN) begin
      for (int i = 0; i < NC; i++) begin
        if (st_old[i] == 1 && core_we[i]) begin
          m_pend[i]  = 1;
          m_paddr[i] = core_addr[16*i +: 8];
          m_pdata[i] = core_wdata[16*i +: 16];
        end
        if (core_end[i]) m_fin[i] = 1;
      end
    end else if (host_we) begin
      m_mem[host_addr] = host_wdata;
      m_known[host_addr] = 1;
    end
    case (m_state)
      M_IDLE: if (start) m_state = M_RUN;
      M_RUN:  if (clear) m_state = M_DONE;
      M_DONE: if (start) begin
        m_state = M_RUN;
        for (int i = 0; i < NC; i++) m_fin[i] = 0;
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clock);
    #1;
    cycle++;
    chk("busy", 16'(busy), 16'(m_state == M_RUN));
    chk("done", 16'(done), 16'(m_state == M_DONE));
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("status%0d", i), 16'(core_status[2*i +: 2]), 16'(m_status(i)));
      if (m_crd_ok[i]) chk($sformatf("rdata%0d", i), core_rdata[16*i +: 16], m_crd[i]);
    end
    if (m_hrd_ok) chk("host_rdata", host_rdata, m_hrd);
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NC; i++) begin
      chk({tag, "_status"}, 16'(core_status[2*i +: 2]), 16'h0);
      chk({tag, "_rdata"}, core_rdata[16*i +: 16], 16'h0);
    end
    chk({tag, "_host_rdata"}, host_rdata, 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_done"}, 16'(done), 16'h0);
  endtask

  initial begin
    int g;
    int n;
    rst_n = 1'b0; start = 1'b0; core_addr = '0; core_wdata = '0;
    core_we = '0; core_end = '0; host_addr = '0; host_wdata = '0; host_we = 1'b0;
    for (int a = 0; a < 256; a++) m_known[a] = 0;
    cyc(); cyc();
    check_reset("reset");
    rst_n = 1'b1;

    // Host load of the whole memory, then readback of a known word
    for (int a = 0; a < 256; a++) begin
      pre[a] = (a == 5) ? 16'h1234 : 16'($urandom);
      host_we = 1'b1; host_addr = 8'(a); host_wdata = pre[a];
      cyc();
    end
    host_we = 1'b0; host_addr = 8'd5;
    cyc();
    chk("host_load", host_rdata, 16'h1234);
    rst_n = 1'b0; cyc();
    check_reset("reset2");
    rst_n = 1'b1; cyc();

    // Contention: two bursts from all cores, grants 0..3 each time
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < NC; i++) chk("start_run", 16'(core_status[2*i +: 2]), 16'h1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NC; i++) begin
        core_addr[16*i +: 16]  = 16'(16 + i + 4*b);
        core_wdata[16*i +: 16] = 16'hA000 + 16'(16*b + i);
      end
      core_we = 4'hF;
      cyc();
      core_we = '0;
      for (int i = 0; i < NC; i++) chk("burst_capture", 16'(core_status[2*i +: 2]), 16'h2);
      for (int k = 1; k <= NC; k++) begin
        cyc();
        for (int i = 0; i < NC; i++)
          chk($sformatf("burst%0d_order%0d", b, k), 16'(core_status[2*i +: 2]),
              (i < k) ? 16'h1 : 16'h2);
      end
    end

    // Fairness: cores 1 and 3 request continuously
    core_addr[16 +: 16] = 16'd30; core_addr[48 +: 16] = 16'd31;
    core_we = 4'b1010;
    cyc();
    for (int j = 0; j < 6; j++) begin
      core_wdata = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      cyc();
      g = (core_status[3:2] == 2'b01) ? 1 : (core_status[7:6] == 2'b01) ? 3 : 15;
      chk("rr_alternate", 16'(g), (j % 2 == 0) ? 16'd1 : 16'd3);
    end
    core_we = '0;
    cyc(); cyc(); cyc();

    // Single uncontended write, observed by core 1 through an aliased address
    core_addr[0 +: 16] = 16'd3; core_addr[16 +: 16] = 16'hAB03;
    core_wdata[0 +: 16] = 16'hBEEF; core_we = 4'b0001;
    cyc();
    core_we = '0;
    chk("sw_stall", 16'(core_status[1:0]), 16'h2);
    chk("sw_old_before", core_rdata[31:16], pre[3]);
    cyc();
    chk("sw_release", 16'(core_status[1:0]), 16'h1);
    chk("sw_old_at_commit", core_rdata[31:16], pre[3]);
    cyc();
    chk("sw_new", core_rdata[31:16], 16'hBEEF);

    // Finish: staggered ends, core 2 last with a simultaneous write
    host_we = 1'b1; host_addr = 8'd40; host_wdata = 16'hDEAD; core_end = 4'b0001;
    cyc();
    host_we = 1'b0;
    chk("fin0", 16'(core_status[1:0]), 16'h3);
    core_end = 4'b0010; cyc();
    chk("fin1", 16'(core_status[3:2]), 16'h3);
    core_end = 4'b1000; cyc();
    chk("fin3", 16'(core_status[7:6]), 16'h3);
    core_end = 4'b0100; core_we = 4'b0100;
    core_addr[32 +: 16] = 16'd50; core_wdata[32 +: 16] = 16'h2222;
    cyc();
    core_end = '0; core_we = '0;
    chk("fin2_stall", 16'(core_status[5:4]), 16'h2);
    chk("fin_not_done", 16'(done), 16'h0);
    cyc();
    chk("fin2_finished", 16'(core_status[5:4]), 16'h3);
    chk("fin_still_busy", 16'(busy), 16'h1);
    chk("fin_done_wait", 16'(done), 16'h0);
    cyc();
    chk("fin_done", 16'(done), 16'h1);
    chk("fin_busy_low", 16'(busy), 16'h0);
    host_addr = 8'd40; cyc();
    chk("host_we_in_run", host_rdata, pre[40]);
    host_addr = 8'd50; cyc();
    chk("fin2_commit", host_rdata, 16'h2222);

    // Reset mid-run with core 1 slot full
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart", 16'(core_status[3:2]), 16'h1);
    core_addr[16 +: 16] = 16'd60; core_wdata[16 +: 16] = 16'h6666; core_we = 4'b0010;
    cyc();
    core_we = '0;
    chk("mid_stall", 16'(core_status[3:2]), 16'h2);
    rst_n = 1'b0; cyc();
    check_reset("mid_rst");
    rst_n = 1'b1; host_addr = 8'd60;
    cyc();
    chk("mid_rst_drop", host_rdata, pre[60]);
    cyc();
    chk("mid_rst_drop_late", host_rdata, pre[60]);
    chk("mid_rst_idle", 16'(core_status), 16'h0);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      start = 1'b1; cyc(); start = 1'b0;
      n = 0;
      while (!done && n < 400) begin
        for (int i = 0; i < NC; i++) begin
          core_addr[16*i +: 16]  = {8'($urandom), 8'($urandom_range(0, 15))};
          core_wdata[16*i +: 16] = 16'($urandom);
        end
        core_we    = 4'($urandom);
        core_end   = (n > 100) ? 4'hF : (($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = 16'($urandom);
        start      = ($urandom_range(0, 7) == 0);
        cyc();
        n++;
      end
      chk("run_done", 16'(done), 16'h1);
      core_we = '0; core_end = '0; start = 1'b0;
      for (int k = 0; k < 5; k++) begin
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = 16'($urandom);
        cyc();
      end
      host_we = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
